spi_ram_slave_gen2: RTL and testbench

- Second-generation SPI slave with integrated single-port RAM, clocked directly by the system clock (MOSI/SS_n sampled on clk).
- Generalised in address width, data width and depth over the fixed 8-bit/256-word slave.
- Adds independent auto-incrementing write/read pointers, out-of-range protection, abort detection and a busy indication.
- Sits at chip top as the host-accessible register/memory port.

---
 rtl/spi_ram_slave_gen2.sv | 152 +++++++++++++++
 tb/tb_spi_ram_slave_gen2.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_slave_gen2.sv
// SPI slave with an integrated single-port RAM. MOSI and SS_n are sampled on the system clock.
// Defining SPI_RAM_AUTO_INC_EN makes wr_ptr/rd_ptr post-increment after each completed data frame.
module spi_ram_slave_gen2 #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy,
   output logic frame_abort
);
   localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int FL = PW + 2;
   localparam int CW = $clog2(FL + 1);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, CHK_CMD, RX, RD_WAIT, TX, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [FL-1:0]           rx_q, rx_d;
   logic [DATA_WIDTH-1:0]   tx_q, tx_d;
   logic                    miso_q, miso_d;
   logic                    abort_q, abort_d;
   logic                    exec_q, exec_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] ptr);
      return {1'b0, ptr} < DEPTH;
   endfunction

`ifdef SPI_RAM_AUTO_INC_EN
   // Pointers at or beyond the last implemented word wrap back to 0.
   function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
      return ({1'b0, ptr} >= DEPTH - 1'b1) ? '0 : ptr + 1'b1;
   endfunction
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      miso_d   = miso_q;
      abort_d  = 1'b0;
      exec_d   = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_we   = 1'b0;

      // A completed non-read frame is executed one edge after its last bit.
      if (exec_q) begin
         case (rx_q[FL-1:FL-2])
            2'b00: wr_ptr_d = rx_q[ADDR_WIDTH-1:0];
            2'b01: begin
               mem_we = in_range(wr_ptr_q);
`ifdef SPI_RAM_AUTO_INC_EN
               wr_ptr_d = next_ptr(wr_ptr_q);
`endif
            end
            2'b10: rd_ptr_d = rx_q[ADDR_WIDTH-1:0];
            default: ;
         endcase
      end

      if (SS_n && (state_q inside {CHK_CMD, RX, RD_WAIT, TX})) begin
         state_d = IDLE;
         abort_d = 1'b1;
         miso_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (!SS_n) state_d = CHK_CMD;
            CHK_CMD, RX: begin
               rx_d    = {rx_q[FL-2:0], MOSI};
               cnt_d   = cnt_q + 1'b1;
               state_d = RX;
               if (state_q == RX && cnt_q == CW'(FL - 1)) begin
                  cnt_d = '0;
                  if (rx_d[FL-1:FL-2] == 2'b11) begin
                     state_d = RD_WAIT;
                  end else begin
                     state_d = DONE;
                     exec_d  = 1'b1;
                  end
               end
            end
            RD_WAIT: begin
               tx_d    = in_range(rd_ptr_q) ? mem[rd_ptr_q] : '0;
               cnt_d   = '0;
               state_d = TX;
            end
            TX: begin
               if (cnt_q == CW'(DATA_WIDTH)) begin
                  miso_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = DONE;
`ifdef SPI_RAM_AUTO_INC_EN
                  rd_ptr_d = next_ptr(rd_ptr_q);
`endif
               end else begin
                  miso_d = tx_q[DATA_WIDTH-1];
                  tx_d   = tx_q << 1;
                  cnt_d  = cnt_q + 1'b1;
               end
            end
            DONE: if (SS_n) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rx_q     <= '0;
         tx_q     <= '0;
         miso_q   <= 1'b0;
         abort_q  <= 1'b0;
         exec_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         miso_q   <= miso_d;
         abort_q  <= abort_d;
         exec_q   <= exec_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // RAM contents survive reset; only the write strobe is blocked by it.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[wr_ptr_q] <= rx_q[DATA_WIDTH-1:0];
   end

   assign MISO        = miso_q;
   assign busy        = (state_q != IDLE);
   assign frame_abort = abort_q;
endmodule

// File: tb/tb_spi_ram_slave_gen2.sv
// Scoreboard bench for spi_ram_slave_gen2: three instances (default, MEM_DEPTH=200, 4-bit addr/16-bit data).
// Output contract: after a complete 11 frame ending at edge t, MISO carries the word MSB first on edges t+2..t+1+DW.
`timescale 1ns/1ps
module tb_spi_ram_slave_gen2;
   localparam int N = 3;
`ifdef SPI_RAM_AUTO_INC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ss_n [N];
   logic mosi [N];
   logic miso [N];
   logic busy [N];
   logic fab  [N];

   int n_cmp = 0;
   int n_bad = 0;
   logic [17:0] exp_q [$];
   logic [15:0] mem_m [N][256];
   bit          wrt_m [N][256];
   int          wr_m [N];
   int          rd_m [N];
   int          exp_abort [N];
   int          seen_abort [N];

   spi_ram_slave_gen2 u0 (
      .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]),
      .MISO(miso[0]), .busy(busy[0]), .frame_abort(fab[0]));
   spi_ram_slave_gen2 #(.MEM_DEPTH(200)) u1 (
      .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]),
      .MISO(miso[1]), .busy(busy[1]), .frame_abort(fab[1]));
   spi_ram_slave_gen2 #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .MEM_DEPTH(16)) u2 (
      .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi[2]),
      .MISO(miso[2]), .busy(busy[2]), .frame_abort(fab[2]));

   // ---------------- clock / watchdog ----------------
   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- per-instance geometry ----------------
   function automatic int fl_of(input int k);  return (k == 2) ? 18 : 10; endfunction
   function automatic int dw_of(input int k);  return (k == 2) ? 16 : 8;  endfunction
   function automatic int aw_of(input int k);  return (k == 2) ? 4  : 8;  endfunction
   function automatic int dep_of(input int k); return (k == 0) ? 256 : ((k == 1) ? 200 : 16); endfunction

   function automatic int inc_ptr(input int k, input int p);
      return (p + 1 >= dep_of(k)) ? 0 : p + 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // abort_at >= 0 raises SS_n after that many bits; rst_bit >= 0 resets during that MISO bit of a read.
   task automatic send_frame(input int k, input logic [1:0] cmd, input logic [15:0] payload,
                             input int abort_at, input int rst_bit);
      int n;
      int amask;
      int dmask;
      logic [15:0] v;
      n     = fl_of(k);
      amask = (1 << aw_of(k)) - 1;
      dmask = (1 << dw_of(k)) - 1;
      if (abort_at < 0 && cmd == 2'b11) begin
         v = (rd_m[k] < dep_of(k)) ? mem_m[k][rd_m[k]] : 16'h0;
         exp_q.push_back({2'(k), v});
         if (AUTO) rd_m[k] = inc_ptr(k, rd_m[k]);
      end
      @(posedge clk);
      #1;
      ss_n[k] = 1'b0;
      mosi[k] = 1'($urandom_range(0, 1));
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         #1;
         if (i == abort_at) begin
            ss_n[k] = 1'b1;
            exp_abort[k]++;
            @(posedge clk);
            @(posedge clk);
            return;
         end
         mosi[k] = (i < 2) ? cmd[1-i] : payload[n-1-i];
         @(posedge clk);
      end
      case (cmd)
         2'b00: wr_m[k] = int'(payload) & amask;
         2'b01: begin
            if (wr_m[k] < dep_of(k)) begin
               mem_m[k][wr_m[k]] = 16'(int'(payload) & dmask);
               wrt_m[k][wr_m[k]] = 1'b1;
            end
            if (AUTO) wr_m[k] = inc_ptr(k, wr_m[k]);
         end
         2'b10: rd_m[k] = int'(payload) & amask;
         default: ;
      endcase
      if (cmd == 2'b11 && rst_bit >= 0) begin
         @(posedge clk);
         repeat (rst_bit + 1) @(posedge clk);
         #1;
         rst = 1'b1;
         ss_n[k] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("rst_miso", 32'(miso[k]), 32'd0);
         check("rst_busy", 32'(busy[k]), 32'd0);
         check("rst_abort", 32'(fab[k]), 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         for (int j = 0; j < N; j++) begin
            wr_m[j] = 0;
            rd_m[j] = 0;
         end
         return;
      end
      if (cmd == 2'b11) repeat (dw_of(k) + 2) @(posedge clk);
      repeat ($urandom_range(0, 3)) begin
         #1;
         mosi[k] = 1'($urandom_range(0, 1));
         @(posedge clk);
      end
      #1;
      ss_n[k] = 1'b1;
      @(posedge clk);
   endtask

   task automatic op(input int k, input logic [1:0] cmd, input logic [15:0] payload);
      send_frame(k, cmd, payload, -1, -1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic monitor(input int k);
      int n;
      logic [1:0] cmd;
      logic [15:0] w;
      logic [17:0] e;
      bit gone;
      n = fl_of(k);
      forever begin
         @(posedge clk);
         if (rst || ss_n[k]) continue;
         @(negedge clk);
         check("busy_start", 32'(busy[k]), 32'd1);
         gone = 1'b0;
         cmd  = 2'b00;
         for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            if (rst) begin gone = 1'b1; break; end
            if (ss_n[k]) begin
               @(negedge clk);
               check("abort_pulse", 32'(fab[k]), 32'd1);
               check("abort_busy", 32'(busy[k]), 32'd0);
               @(negedge clk);
               check("abort_end", 32'(fab[k]), 32'd0);
               gone = 1'b1;
               break;
            end
            if (i <= 2) cmd = {cmd[0], mosi[k]};
         end
         if (gone) continue;
         if (cmd == 2'b11) begin
            e = 18'h0;
            if (exp_q.size() == 0) check("exp_underflow", 32'd0, 32'd1);
            else e = exp_q.pop_front();
            check("rd_tag", 32'(e[17:16]), 32'(k));
            @(posedge clk);
            w = 16'h0;
            for (int b = 0; b < dw_of(k); b++) begin
               @(posedge clk);
               if (rst) begin gone = 1'b1; break; end
               @(negedge clk);
               w = {w[14:0], miso[k]};
            end
            if (gone) continue;
            check("rd_data", 32'(w), 32'(e[15:0]));
            @(posedge clk);
            @(negedge clk);
            check("miso_idle", 32'(miso[k]), 32'd0);
         end
         while (1'b1) begin
            @(posedge clk);
            if (rst || ss_n[k]) break;
         end
         if (!rst) begin
            @(negedge clk);
            check("busy_end", 32'(busy[k]), 32'd0);
         end
      end
   endtask

   initial begin
      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none
   end

   initial forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (fab[k] === 1'b1) seen_abort[k]++;
   end

   // ---------------- main sequence ----------------
   initial begin
      int k;
      int addr;
      int dep;
      logic [15:0] ap;
      for (int i = 0; i < N; i++) begin
         ss_n[i] = 1'b1;
         mosi[i] = 1'b0;
         wr_m[i] = 0;
         rd_m[i] = 0;
         exp_abort[i] = 0;
         seen_abort[i] = 0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check("reset_miso", 32'(miso[i]), 32'd0);
         check("reset_busy", 32'(busy[i]), 32'd0);
         check("reset_abort", 32'(fab[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic write/read of 0xA5 at 0x3C
      op(0, 2'b00, 16'h3C); op(0, 2'b01, 16'hA5); op(0, 2'b10, 16'h3C); op(0, 2'b11, 16'h00);
      // pointer auto-increment / wrap at the top of the address space
      op(0, 2'b00, 16'hFF); op(0, 2'b01, 16'h11); op(0, 2'b01, 16'h22);
      op(0, 2'b10, 16'hFF); op(0, 2'b11, 16'h00); op(0, 2'b11, 16'h00);
      // abort after 5 bits leaves RAM and wr_ptr untouched
      op(0, 2'b00, 16'h40); op(0, 2'b01, 16'h33); op(0, 2'b00, 16'h40);
      send_frame(0, 2'b01, 16'h5A, 5, -1);
      op(0, 2'b10, 16'h40); op(0, 2'b11, 16'h00);
      op(0, 2'b01, 16'h5A); op(0, 2'b10, 16'h40); op(0, 2'b11, 16'h00);
      // reset during MISO bit 3 of a read
      op(0, 2'b00, 16'h00); op(0, 2'b01, 16'hC3); op(0, 2'b10, 16'h3C);
      send_frame(0, 2'b11, 16'h00, -1, 3);
      op(0, 2'b11, 16'h00);
      op(0, 2'b01, 16'h6B); op(0, 2'b10, 16'h00); op(0, 2'b11, 16'h00);
      // out-of-range pointers on the 200-word instance
      op(1, 2'b00, 16'h00); op(1, 2'b01, 16'h99);
      op(1, 2'b00, 16'hC8); op(1, 2'b01, 16'h77); op(1, 2'b10, 16'hC8); op(1, 2'b11, 16'h00);
      op(1, 2'b01, 16'h44); op(1, 2'b10, 16'h00); op(1, 2'b11, 16'h00);
      // 4-bit address / 16-bit data; upper address payload bits must be ignored
      op(2, 2'b00, 16'hFFF3); op(2, 2'b01, 16'hBEEF); op(2, 2'b10, 16'h1233); op(2, 2'b11, 16'h0000);

      for (int r = 0; r < 60; r++) begin
         k    = $urandom_range(0, N - 1);
         dep  = dep_of(k);
         addr = $urandom_range(0, (1 << aw_of(k)) - 1);
         ap   = 16'(($urandom() & ~((1 << aw_of(k)) - 1)) | addr);
         case ($urandom_range(0, 3))
            0, 1: begin
               op(k, 2'b00, ap);
               op(k, 2'b01, 16'($urandom()));
            end
            2: begin
               if (addr < dep && !wrt_m[k][addr]) begin
                  op(k, 2'b00, ap);
                  op(k, 2'b01, 16'($urandom()));
               end
               op(k, 2'b10, ap);
               op(k, 2'b11, 16'($urandom()));
            end
            default: send_frame(k, 2'($urandom_range(0, 3)), 16'($urandom()),
                                $urandom_range(0, fl_of(k) - 1), -1);
         endcase
      end

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      check("exp_drain", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < N; i++) check("abort_count", 32'(seen_abort[i]), 32'(exp_abort[i]));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
